// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM encodings,
// register offsets and STATUS bit positions.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// MEM-stage data-bus slice seen by the UART peripheral; rdata is combinational.
interface uart_tx_mmio_if;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read: pop_data is valid the cycle after pop
// and holds until the next pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign pop_data = rd_data_reg;

  // A push is judged against fullness before any same-cycle pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
    if (do_pop) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus stores fill a TX FIFO, a baud-timed
// FSM serialises bytes LSB first, loads return status and occupancy.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           irq
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);

  state_t        state_reg, state_next;
  logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          overflow_reg;

  logic          push;
  logic          pop;
  logic          ovf_clr;
  logic          baud_done;
  logic [7:0]    fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic [31:0]   count_word;
  logic [31:0]   status_word;
  logic [31:0]   rdata_word;
  logic          unused_wdata;

  assign push      = bus.sel & bus.we & (bus.addr == OFF_TXDATA);
  assign ovf_clr   = bus.sel & bus.we & (bus.addr == OFF_STATUS) & bus.wdata[STAT_OVF];
  assign baud_done = (baud_cnt_reg == CW'(DIV - 1));
  assign unused_wdata = ^bus.wdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.wdata[7:0]),
    .pop       (pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    pop           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          baud_cnt_next = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        // The FIFO's registered read lands during START, so the byte is taken here.
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_idx_next  = 3'd0;
          shift_next    = fifo_rd_data;
          state_next    = ST_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      if (push && fifo_full) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // tx decodes straight from state so an asserted reset forces the line idle at once.
  always_comb begin
    case (state_reg)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shift_reg[0];
      default:  tx = 1'b1;
    endcase
  end

  assign irq = fifo_empty & (state_reg == ST_IDLE);

  genvar gi;
  for (gi = 0; gi < 32; gi++) begin : g_count
    if (gi <= AW) begin : g_bit
      assign count_word[gi] = fifo_count[gi];
    end else begin : g_zero
      assign count_word[gi] = 1'b0;
    end
  end

  always_comb begin
    status_word            = '0;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_BUSY]  = (state_reg != ST_IDLE);
    status_word[STAT_OVF]   = overflow_reg;
  end

  always_comb begin
    rdata_word = '0;
    if (bus.sel && !bus.we && rst) begin
      case (bus.addr)
        OFF_STATUS: rdata_word = status_word;
        OFF_COUNT:  rdata_word = count_word;
        default:    rdata_word = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_word;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: bytes accepted on the bus are queued and
// matched against frames decoded from the tx line.
module tb_uart_tx_mmio;
  import uart_pkg::*;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic irq;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .CLK_FREQ   (1000),
    .BAUD       (100),
    .FIFO_DEPTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;
  int frames  = 0;
  logic [7:0] exp_q [$];
  int         start_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input bit accept);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    if (accept) exp_q.push_back(d[7:0]);
    @(posedge clk);
    #1;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    $display("write addr=0x%0h data=0x%0h", a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.rdata;
    bus.sel = 1'b0;
    $display("read  addr=0x%0h data=0x%0h", a, d);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(irq === 1'b1 && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_wait", (n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic exp_wave(input int j, input logic [7:0] b);
    int k;
    if (j == 0) return 1'b1;
    k = (j - 1) / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Line monitor: decodes each frame by mid-bit sampling and checks it against the scoreboard.
  initial begin : monitor
    logic [9:0] samp;
    bit         aborted;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        t0      = cyc;
        aborted = 0;
        samp    = '0;
        for (int c = 0; c < 10 * DIV; c++) begin
          if (c > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (c % DIV == DIV / 2) samp[c / DIV] = tx;
        end
        if (!aborted) begin
          frames++;
          start_q.push_back(t0);
          check_eq("start_bit", samp[0], 0);
          check_eq("stop_bit", samp[9], 1);
          check_eq("sb_nonempty", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check_eq("frame_byte", samp[8:1], exp_q.pop_front());
          $display("frame %0d at cycle %0d byte=0x%02h", frames, t0, samp[8:1]);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    int f0;
    int s0;
    int lows;

    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_irq", irq, 1);
    bus_read(OFF_STATUS, d);
    check_eq("rst_rdata", d, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_tx", tx, 1);
    check_eq("post_rst_irq", irq, 1);
    bus_read(OFF_STATUS, d);
    check_eq("post_rst_status", d, 32'h2);
    bus_read(OFF_COUNT, d);
    check_eq("post_rst_count", d, 0);

    // Single byte: exact waveform including the pop cycle
    bus_write(OFF_TXDATA, 32'h0A5, 1);
    for (int j = 0; j <= 100; j++) begin
      @(negedge clk);
      check_eq("tx_wave", tx, exp_wave(j, 8'hA5));
      if (j == 50) begin
        check_eq("busy_irq", irq, 0);
        bus_read(OFF_STATUS, d);
        check_eq("busy_status", d, 32'h6);
      end
    end
    @(negedge clk);
    check_eq("done_irq", irq, 1);
    check_eq("done_tx", tx, 1);
    #1;
    bus_read(OFF_STATUS, d);
    check_eq("done_status", d, 32'h2);
    wait_idle(50);
    check_eq("single_frames", frames, 1);

    // Back-to-back frames
    f0 = frames;
    s0 = start_q.size();
    bus_write(OFF_TXDATA, 32'h55, 1);
    bus_write(OFF_TXDATA, 32'hC3, 1);
    repeat (30) @(negedge clk);
    #1;
    bus_read(OFF_COUNT, d);
    check_eq("b2b_count", d, 1);
    wait_idle(400);
    check_eq("b2b_frames", frames - f0, 2);
    if (start_q.size() >= s0 + 2)
      check_eq("b2b_gap", start_q[s0+1] - start_q[s0], 10 * DIV);
    else
      check_eq("b2b_starts", start_q.size() - s0, 2);

    // Overflow: 18 pushes, the 18th is dropped
    f0 = frames;
    for (int i = 0; i < 18; i++)
      bus_write(OFF_TXDATA, 32'hABCD_EF00 | (32'h10 + i), (i < 17));
    bus_read(OFF_COUNT, d);
    check_eq("ovf_count_peak", d, 16);
    bus_read(OFF_STATUS, d);
    check_eq("ovf_bit3", d[3], 1);
    check_eq("ovf_bit0", d[0], 1);
    check_eq("ovf_status", d, 32'hD);
    bus_write(OFF_STATUS, 32'h8, 0);
    bus_read(OFF_STATUS, d);
    check_eq("ovf_cleared", d, 32'h5);
    wait_idle(2200);
    check_eq("ovf_frames", frames - f0, 17);

    // Reset during DATA bit 3 (byte 0x35 has bit3 = 0)
    f0 = frames;
    bus_write(OFF_TXDATA, 32'h35, 1);
    bus_write(OFF_TXDATA, 32'h3C, 1);
    repeat (44) @(negedge clk);
    check_eq("mid_frame_tx", tx, 0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_tx_immediate", tx, 1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    bus_read(OFF_STATUS, d);
    check_eq("mid_rst_status", d, 32'h2);
    bus_read(OFF_COUNT, d);
    check_eq("mid_rst_count", d, 0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check_eq("mid_rst_line_idle", lows, 0);
    check_eq("mid_rst_frames", frames - f0, 0);

    // Bus decode while a frame is running
    f0 = frames;
    #1;
    bus_write(OFF_TXDATA, 32'h11, 1);
    bus_write(OFF_TXDATA, 32'h22, 1);
    bus_read(4'hC, d);
    check_eq("rd_undef", d, 0);
    bus_read(OFF_TXDATA, d);
    check_eq("rd_txdata", d, 0);
    bus_write(4'hC, 32'hFF, 0);
    bus_read(OFF_COUNT, d);
    check_eq("wr_undef_count", d, 1);
    bus.sel = 1'b0; bus.we = 1'b1; bus.addr = OFF_TXDATA; bus.wdata = 32'h77;
    @(posedge clk); #1;
    bus.we = 1'b0;
    bus_read(OFF_COUNT, d);
    check_eq("nosel_count", d, 1);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = OFF_STATUS; bus.wdata = '0;
    #1;
    check_eq("rdata_on_store", bus.rdata, 0);
    bus.sel = 1'b0; bus.we = 1'b0;
    wait_idle(400);
    check_eq("decode_frames", frames - f0, 2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
